hazard_forward_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MA/WB).
- Generates per-stage clock enables, bubble/flush controls and EX operand forwarding selects.
- Supports multi-cycle load-use stalls, multi-cycle branch flush windows and memory-wait freezes, sequenced by an internal state machine.

---
 rtl/hazard_forward_unit.sv | 195 +++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: hazard / forwarding controller for the 5-stage RV32I pipeline.
// Produces stage clock enables, bubble/flush controls and EX operand forwarding
// selects. A small FSM (RUN / LOAD_STALL / BR_FLUSH) sequences multi-cycle
// load-use stalls and branch flush windows; data-memory waits freeze everything.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush performance counters;
// without it the counter outputs are tied to zero and no counter flops exist.

// Per-operand forwarding select: MA result beats WB result, x0 never forwards,
// and a load still in MA cannot forward (its data is not available yet).
module hazard_fwd_sel #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ma_rd,
    input  logic                  ma_reg_wr,
    input  logic                  ma_mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_wr,
    output logic [1:0]            sel
);
    // priority select, 2'b11 is never produced
    always_comb begin
        sel = 2'b00;
        if (ma_reg_wr && ma_rd != '0 && ma_rd == ex_rs && !ma_mem_rd)
            sel = 2'b01;
        else if (wb_reg_wr && wb_rd != '0 && wb_rd == ex_rs)
            sel = 2'b10;
    end
endmodule

module hazard_forward_unit #(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int BRANCH_PENALTY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_instr_ready,
    input  logic                  i_data_ready,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rs1,
    input  logic [REG_ADDR_W-1:0] i_ex_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_reg_wr,
    input  logic                  i_ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] i_ma_rd,
    input  logic                  i_ma_reg_wr,
    input  logic                  i_ma_mem_rd,
    input  logic                  i_ma_mem_req,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_wb_reg_wr,
    input  logic                  i_ex_branch_taken,
    output logic                  o_if_clk_en,
    output logic                  o_id_clk_en,
    output logic                  o_ex_clk_en,
    output logic                  o_ma_clk_en,
    output logic                  o_id_flush,
    output logic                  o_ex_flush,
    output logic                  o_wb_bubble,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic [31:0]           o_stall_cnt,
    output logic [31:0]           o_flush_cnt
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, BR_FLUSH} state_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_USE_STALL - 1);
    localparam logic [2:0] BR_INIT = 3'(BRANCH_PENALTY - 1);

    state_t     state;
    logic [2:0] cnt;

    logic load_use, mem_wait;
    logic [1:0][REG_ADDR_W-1:0] ex_rs;
    logic [1:0][1:0]            fwd_sel;

    assign load_use = i_ex_mem_rd && i_ex_reg_wr && (i_ex_rd != '0) &&
                      ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) ||
                       (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
    assign mem_wait = i_ma_mem_req && !i_data_ready;

    assign ex_rs[0] = i_ex_rs1;
    assign ex_rs[1] = i_ex_rs2;

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
            .ex_rs     (ex_rs[g]),
            .ma_rd     (i_ma_rd),
            .ma_reg_wr (i_ma_reg_wr),
            .ma_mem_rd (i_ma_mem_rd),
            .wb_rd     (i_wb_rd),
            .wb_reg_wr (i_wb_reg_wr),
            .sel       (fwd_sel[g])
        );
    end

    // forwarding selects are forced to regfile while reset is held
    assign o_fwd_a = rst ? 2'b00 : fwd_sel[0];
    assign o_fwd_b = rst ? 2'b00 : fwd_sel[1];

    // pipeline controls: reset > mem wait > branch > flush window > load stall > fetch wait
    always_comb begin
        o_if_clk_en = 1'b1;
        o_id_clk_en = 1'b1;
        o_ex_clk_en = 1'b1;
        o_ma_clk_en = 1'b1;
        o_id_flush  = 1'b0;
        o_ex_flush  = 1'b0;
        o_wb_bubble = 1'b0;
        if (rst) begin
            o_if_clk_en = 1'b0;
            o_id_clk_en = 1'b0;
            o_ex_clk_en = 1'b0;
            o_ma_clk_en = 1'b0;
        end else if (mem_wait) begin
            o_if_clk_en = 1'b0;
            o_id_clk_en = 1'b0;
            o_ex_clk_en = 1'b0;
            o_ma_clk_en = 1'b0;
            o_wb_bubble = 1'b1;
        end else if (i_ex_branch_taken) begin
            o_id_flush  = 1'b1;
            o_ex_flush  = 1'b1;
        end else if (state == BR_FLUSH) begin
            o_id_flush  = 1'b1;
        end else if (state == LOAD_STALL || load_use) begin
            o_if_clk_en = 1'b0;
            o_id_clk_en = 1'b0;
            o_ex_flush  = 1'b1;
        end else if (!i_instr_ready) begin
            o_if_clk_en = 1'b0;
            o_id_flush  = 1'b1;
        end
    end

    // hazard sequencer; a memory wait freezes state and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (mem_wait) begin
            state <= state;
            cnt   <= cnt;
        end else if (i_ex_branch_taken) begin
            // a branch discards any pending load stall
            if (BRANCH_PENALTY > 1) begin
                state <= BR_FLUSH;
                cnt   <= BR_INIT;
            end else begin
                state <= RUN;
                cnt   <= '0;
            end
        end else begin
            case (state)
                BR_FLUSH: begin
                    // window only advances when a real fetch arrives
                    if (i_instr_ready) begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) state <= RUN;
                    end
                end
                LOAD_STALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= RUN;
                end
                default: begin
                    if (load_use && LOAD_USE_STALL > 1) begin
                        state <= LOAD_STALL;
                        cnt   <= LU_INIT;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // stall counts fetch-frozen cycles, flush counts any ID/EX bubble injection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (!o_if_clk_en)              o_stall_cnt <= o_stall_cnt + 32'd1;
            if (o_id_flush || o_ex_flush)  o_flush_cnt <= o_flush_cnt + 32'd1;
        end
    end
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard bench for hazard_forward_unit
// (LOAD_USE_STALL=2, BRANCH_PENALTY=3). Expected control vectors are queued
// when a cycle's stimulus is driven and popped when outputs are sampled.
module tb_hazard_forward_unit;
    localparam int W = 5;

    // control vector: {if_en, id_en, ex_en, ma_en, id_flush, ex_flush, wb_bubble}
    localparam logic [6:0] NORM   = 7'b1111_000;
    localparam logic [6:0] LSTALL = 7'b0011_010;
    localparam logic [6:0] MWAIT  = 7'b0000_001;
    localparam logic [6:0] BRNOW  = 7'b1111_110;
    localparam logic [6:0] BRWIN  = 7'b1111_100;
    localparam logic [6:0] FWAIT  = 7'b0111_100;
    localparam logic [6:0] RSTV   = 7'b0000_000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_ready, data_ready, id_use_rs1, id_use_rs2;
    logic [W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ma_rd, wb_rd;
    logic ex_reg_wr, ex_mem_rd, ma_reg_wr, ma_mem_rd, ma_mem_req, wb_reg_wr, br_taken;
    logic if_en, id_en, ex_en, ma_en, id_flush, ex_flush, wb_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_bad = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(W), .LOAD_USE_STALL(2), .BRANCH_PENALTY(3)) dut (
        .clk(clk), .rst(rst),
        .i_instr_ready(instr_ready), .i_data_ready(data_ready),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
        .i_ex_rd(ex_rd), .i_ex_reg_wr(ex_reg_wr), .i_ex_mem_rd(ex_mem_rd),
        .i_ma_rd(ma_rd), .i_ma_reg_wr(ma_reg_wr), .i_ma_mem_rd(ma_mem_rd),
        .i_ma_mem_req(ma_mem_req),
        .i_wb_rd(wb_rd), .i_wb_reg_wr(wb_reg_wr),
        .i_ex_branch_taken(br_taken),
        .o_if_clk_en(if_en), .o_id_clk_en(id_en), .o_ex_clk_en(ex_en), .o_ma_clk_en(ma_en),
        .o_id_flush(id_flush), .o_ex_flush(ex_flush), .o_wb_bubble(wb_bubble),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        instr_ready = 1'b1; data_ready = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_wr = 1'b0; ex_mem_rd = 1'b0;
        ma_rd = '0; ma_reg_wr = 1'b0; ma_mem_rd = 1'b0; ma_mem_req = 1'b0;
        wb_rd = '0; wb_reg_wr = 1'b0; br_taken = 1'b0;
    endtask

    task automatic load_use5();
        ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    // one pipeline cycle: queue expectation, sample mid-cycle, advance past the edge
    task automatic cyc(input string tag, input logic [6:0] ctl, input logic [3:0] fwd);
        exp_t e;
        e.tag = tag;
        e.v   = {ctl, fwd};
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk(e.tag, 32'({if_en, id_en, ex_en, ma_en, id_flush, ex_flush, wb_bubble, fwd_a, fwd_b}),
            32'(e.v));
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!ctl[6]) exp_stall++;
            if (ctl[2] || ctl[1]) exp_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stall"}, stall_cnt, 32'(exp_stall));
        chk({tag, "_flush"}, flush_cnt, 32'(exp_flush));
`else
        chk({tag, "_stall"}, stall_cnt, 32'd0);
        chk({tag, "_flush"}, flush_cnt, 32'd0);
`endif
    endtask

    initial begin
        idle();
        // reset with matching forward sources and a load-use present
        ma_rd = 5'd3; ma_reg_wr = 1'b1; ex_rs1 = 5'd3; load_use5();
        #3;
        chk("rst_ctl", 32'({if_en, id_en, ex_en, ma_en, id_flush, ex_flush, wb_bubble}), 32'(RSTV));
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk_cnt("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        cyc("run", NORM, 4'b0000);

        // forwarding
        ma_rd = 5'd3; ma_reg_wr = 1'b1; wb_rd = 5'd3; wb_reg_wr = 1'b1; ex_rs1 = 5'd3;
        cyc("fwd_ma", NORM, 4'b0100);
        ma_mem_rd = 1'b1;
        cyc("fwd_ld_wb", NORM, 4'b1000);
        ex_rs1 = 5'd0;
        cyc("fwd_x0", NORM, 4'b0000);
        ma_mem_rd = 1'b0; ex_rs1 = 5'd7; ex_rs2 = 5'd3;
        cyc("fwd_b_ma", NORM, 4'b0001);
        ma_reg_wr = 1'b0;
        cyc("fwd_b_wb", NORM, 4'b0010);
        wb_rd = 5'd0; ex_rs2 = 5'd0;
        cyc("fwd_wb_x0", NORM, 4'b0000);
        idle();

        // fetch wait
        instr_ready = 1'b0;
        cyc("fetch_wait", FWAIT, 4'b0000);
        idle();

        // load-use: two stall cycles then normal
        load_use5();
        cyc("lu_0", LSTALL, 4'b0000);
        idle();
        cyc("lu_1", LSTALL, 4'b0000);
        cyc("lu_done", NORM, 4'b0000);
        // no hazard when the load targets x0 or the ID source is unused
        load_use5(); ex_rd = 5'd0; id_rs1 = 5'd0;
        cyc("lu_x0", NORM, 4'b0000);
        load_use5(); id_use_rs1 = 1'b0;
        cyc("lu_unused", NORM, 4'b0000);
        idle();
        load_use5(); id_rs1 = 5'd0; id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        cyc("lu_rs2", LSTALL, 4'b0000);
        idle();
        cyc("lu_rs2_1", LSTALL, 4'b0000);
        cyc("lu_rs2_done", NORM, 4'b0000);

        // memory wait freezes LOAD_STALL with one cycle left
        load_use5();
        cyc("mw_lu", LSTALL, 4'b0000);
        idle();
        ma_mem_req = 1'b1; data_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc($sformatf("mw_%0d", i), MWAIT, 4'b0000);
        idle();
        cyc("mw_resume", LSTALL, 4'b0000);
        cyc("mw_done", NORM, 4'b0000);

        // branch during memory wait is ignored
        ma_mem_req = 1'b1; data_ready = 1'b0; br_taken = 1'b1;
        cyc("mw_br", MWAIT, 4'b0000);
        idle();
        cyc("mw_br_after", NORM, 4'b0000);

        // branch window with fetch stalls in the middle: id_flush for 5 cycles
        br_taken = 1'b1;
        cyc("br_0", BRNOW, 4'b0000);
        idle();
        cyc("br_1", BRWIN, 4'b0000);
        instr_ready = 1'b0;
        cyc("br_2", BRWIN, 4'b0000);
        cyc("br_3", BRWIN, 4'b0000);
        instr_ready = 1'b1;
        cyc("br_4", BRWIN, 4'b0000);
        cyc("br_done", NORM, 4'b0000);

        // simultaneous load-use and branch: branch only
        load_use5(); br_taken = 1'b1;
        cyc("lubr_0", BRNOW, 4'b0000);
        idle();
        cyc("lubr_1", BRWIN, 4'b0000);
        cyc("lubr_2", BRWIN, 4'b0000);
        cyc("lubr_done", NORM, 4'b0000);

        // branch during LOAD_STALL discards the stall
        load_use5();
        cyc("stbr_lu", LSTALL, 4'b0000);
        idle(); br_taken = 1'b1;
        cyc("stbr_br", BRNOW, 4'b0000);
        idle();
        cyc("stbr_1", BRWIN, 4'b0000);
        cyc("stbr_2", BRWIN, 4'b0000);
        cyc("stbr_done", NORM, 4'b0000);
        chk_cnt("mid");

        // asynchronous reset inside the flush window (cnt=2)
        br_taken = 1'b1;
        cyc("rbr_0", BRNOW, 4'b0000);
        idle();
        ma_rd = 5'd4; ma_reg_wr = 1'b1; ex_rs2 = 5'd4;
        rst = 1'b1;
        cyc("rbr_rst", RSTV, 4'b0000);
        chk_cnt("rst2");
        rst = 1'b0;
        idle();
        cyc("rbr_run0", NORM, 4'b0000);
        cyc("rbr_run1", NORM, 4'b0000);
        chk_cnt("end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
